// File: rtl/sccb_slave_model_if.sv
// SCCB pin bundle between a master (or bench) and the slave model.
// The master drives SIO_C and the resolved SIO_D pad value; the slave returns its pad drive.
interface sccb_slave_model_if;
    logic SIO_C;
    logic SIO_DI;
    logic SIO_DO;
    logic SIO_DE;

    modport master (
        output SIO_C,
        output SIO_DI,
        input  SIO_DO,
        input  SIO_DE
    );

    modport slave (
        input  SIO_C,
        input  SIO_DI,
        output SIO_DO,
        output SIO_DE
    );
endinterface

// File: rtl/sccb_slave_model.sv
// SCCB responder with a 256x8 register file, standing in for the camera sensor.
// Define SCCB_SLV_AUTOINC_EN to step the sub-address after every data byte.
module sccb_slave_model #(
    parameter logic [6:0] DEV_ID   = 7'h21,
    parameter logic [7:0] REG_INIT = 8'h00
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    sccb_slave_model_if.slave bus,
    output logic              WR_STB,
    output logic [7:0]        WR_ADDR,
    output logic [7:0]        WR_DATA,
    input  logic [7:0]        DBG_ADDR,
    output logic [7:0]        DBG_DATA
);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] DEV_ADDR  = 4'd1;
    localparam logic [3:0] DEV_ACK   = 4'd2;
    localparam logic [3:0] SUB_ADDR  = 4'd3;
    localparam logic [3:0] SUB_ACK   = 4'd4;
    localparam logic [3:0] WDATA     = 4'd5;
    localparam logic [3:0] WDATA_ACK = 4'd6;
    localparam logic [3:0] RDATA     = 4'd7;
    localparam logic [3:0] RDATA_NA  = 4'd8;
    localparam logic [3:0] IGNORE    = 4'd9;

    logic       c_s1, c_s2, c_d;
    logic       d_s1, d_s2, d_d;
    logic       scl_rise, scl_fall;
    logic       bus_start, bus_stop;
    logic [3:0] state;
    logic [3:0] bit_cnt;
    logic [7:0] sh;
    logic [7:0] tx;
    logic [7:0] sub;
    logic       rw;
    logic       de_q, do_q;
    logic [7:0] mem [256];
    logic [7:0] rx_byte;

    // Syncs idle high so leaving reset never fakes a START.
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            c_s1 <= 1'b1;
            c_s2 <= 1'b1;
            c_d  <= 1'b1;
            d_s1 <= 1'b1;
            d_s2 <= 1'b1;
            d_d  <= 1'b1;
        end else begin
            c_s1 <= bus.SIO_C;
            c_s2 <= c_s1;
            c_d  <= c_s2;
            d_s1 <= bus.SIO_DI;
            d_s2 <= d_s1;
            d_d  <= d_s2;
        end
    end

    assign scl_rise  = c_s2 & ~c_d;
    assign scl_fall  = ~c_s2 & c_d;
    assign bus_start = c_s2 & c_d & d_d & ~d_s2;
    assign bus_stop  = c_s2 & c_d & ~d_d & d_s2;
    assign rx_byte   = {sh[6:0], d_s2};

    assign bus.SIO_DE = de_q;
    assign bus.SIO_DO = do_q & de_q;

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            state    <= IDLE;
            bit_cnt  <= 4'd0;
            sh       <= 8'h00;
            tx       <= 8'h00;
            sub      <= 8'h00;
            rw       <= 1'b0;
            de_q     <= 1'b0;
            do_q     <= 1'b0;
            WR_STB   <= 1'b0;
            WR_ADDR  <= 8'h00;
            WR_DATA  <= 8'h00;
            DBG_DATA <= 8'h00;
            for (int i = 0; i < 256; i++) mem[i] <= REG_INIT;
        end else begin
            WR_STB   <= 1'b0;
            DBG_DATA <= mem[DBG_ADDR];
            if (bus_start) begin
                state   <= DEV_ADDR;
                bit_cnt <= 4'd0;
                de_q    <= 1'b0;
                do_q    <= 1'b0;
            end else if (bus_stop) begin
                state   <= IDLE;
                bit_cnt <= 4'd0;
                de_q    <= 1'b0;
                do_q    <= 1'b0;
            end else if (scl_rise) begin
                sh <= rx_byte;
                unique case (state)
                    DEV_ADDR, SUB_ADDR, RDATA: bit_cnt <= bit_cnt + 4'd1;
                    WDATA: begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            mem[sub] <= rx_byte;
                            WR_STB   <= 1'b1;
                            WR_ADDR  <= sub;
                            WR_DATA  <= rx_byte;
`ifdef SCCB_SLV_AUTOINC_EN
                            sub      <= sub + 8'd1;
`else
                            sub      <= sub;
`endif
                        end
                    end
                    RDATA_NA: if (d_s2) state <= IGNORE;
                    default: ;
                endcase
            end else if (scl_fall) begin
                unique case (state)
                    DEV_ADDR: if (bit_cnt == 4'd8) begin
                        if (sh[7:1] == DEV_ID) begin
                            state <= DEV_ACK;
                            rw    <= sh[0];
                            de_q  <= 1'b1;
                            do_q  <= 1'b0;
                        end else begin
                            state <= IGNORE;
                        end
                    end
                    DEV_ACK: begin
                        bit_cnt <= 4'd0;
                        if (rw) begin
                            state <= RDATA;
                            tx    <= mem[sub];
                            do_q  <= mem[sub][7];
                            de_q  <= 1'b1;
                        end else begin
                            state <= SUB_ADDR;
                            de_q  <= 1'b0;
                            do_q  <= 1'b0;
                        end
                    end
                    SUB_ADDR: if (bit_cnt == 4'd8) begin
                        state <= SUB_ACK;
                        sub   <= sh;
                        de_q  <= 1'b1;
                        do_q  <= 1'b0;
                    end
                    SUB_ACK, WDATA_ACK: begin
                        state   <= WDATA;
                        bit_cnt <= 4'd0;
                        de_q    <= 1'b0;
                        do_q    <= 1'b0;
                    end
                    WDATA: if (bit_cnt == 4'd8) begin
                        state <= WDATA_ACK;
                        de_q  <= 1'b1;
                        do_q  <= 1'b0;
                    end
                    RDATA: begin
                        if (bit_cnt == 4'd8) begin
                            state   <= RDATA_NA;
                            bit_cnt <= 4'd0;
                            de_q    <= 1'b0;
                            do_q    <= 1'b0;
`ifdef SCCB_SLV_AUTOINC_EN
                            sub     <= sub + 8'd1;
`endif
                        end else begin
                            do_q <= tx[6];
                            tx   <= {tx[6:0], 1'b0};
                        end
                    end
                    // Master acked the byte: reload and keep streaming.
                    RDATA_NA: begin
                        state   <= RDATA;
                        bit_cnt <= 4'd0;
                        tx      <= mem[sub];
                        do_q    <= mem[sub][7];
                        de_q    <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sccb_slave_model.sv
// Directed bench for sccb_slave_model: bit-banged SCCB master with a wired pad model.
// Expected values are hand-computed per transaction.
module tb_sccb_slave_model;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_sda = 1'b1;
    logic       wr_stb;
    logic [7:0] wr_addr, wr_data;
    logic [7:0] dbg_addr = 8'h00;
    logic [7:0] dbg_data;
    int         n_pass = 0;
    int         n_chk = 0;
    int         stb_cnt = 0;
    int         de_cnt = 0;

    sccb_slave_model_if sio ();

    assign sio.SIO_DI = sio.SIO_DE ? sio.SIO_DO : m_sda;

    sccb_slave_model u_dut (
        .PCLK     (clk),
        .PRESETN  (rst_n),
        .bus      (sio),
        .WR_STB   (wr_stb),
        .WR_ADDR  (wr_addr),
        .WR_DATA  (wr_data),
        .DBG_ADDR (dbg_addr),
        .DBG_DATA (dbg_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_stb) stb_cnt++;
        if (sio.SIO_DE) de_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic wt(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic m_start;
        m_sda = 1'b1;
        wt(Q);
        sio.SIO_C = 1'b1;
        wt(Q);
        m_sda = 1'b0;
        wt(Q);
        sio.SIO_C = 1'b0;
        wt(Q);
    endtask

    task automatic m_stop;
        m_sda = 1'b0;
        wt(Q);
        sio.SIO_C = 1'b1;
        wt(Q);
        m_sda = 1'b1;
        wt(Q);
    endtask

    task automatic clk_bit(input logic b, output logic s, output logic de);
        m_sda = b;
        wt(Q);
        sio.SIO_C = 1'b1;
        wt(Q / 2);
        @(negedge clk);
        s  = sio.SIO_DI;
        de = sio.SIO_DE;
        wt(Q / 2);
        sio.SIO_C = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic [1:0] ack);
        logic s, e;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s, e);
        clk_bit(1'b1, s, e);
        ack = {e, s};
    endtask

    task automatic rd_byte(input logic na, output logic [7:0] d,
                           output logic de9);
        logic s, e;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s, e);
            d[i] = s;
        end
        clk_bit(na, s, de9);
    endtask

    task automatic dbg(input logic [7:0] a, output logic [7:0] d);
        dbg_addr = a;
        @(posedge clk);
        @(negedge clk);
        d = dbg_data;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] ack;
        logic [7:0] d;
        logic       de9, s, e;
        int         s0, d0;

        sio.SIO_C = 1'b1;
        wt(4);
        @(negedge clk);
        chk("rst_de", sio.SIO_DE, 0);
        chk("rst_do", sio.SIO_DO, 0);
        chk("rst_stb", wr_stb, 0);
        chk("rst_waddr", wr_addr, 0);
        chk("rst_wdata", wr_data, 0);
        chk("rst_dbg", dbg_data, 0);
        rst_n = 1'b1;
        wt(4);

        // 3-phase write 42/12/80
        s0 = stb_cnt;
        m_start;
        wr_byte(8'h42, ack);
        chk("w_ack_dev", ack, 2'b10);
        wr_byte(8'h12, ack);
        chk("w_ack_sub", ack, 2'b10);
        wr_byte(8'h80, ack);
        chk("w_ack_dat", ack, 2'b10);
        m_stop;
        chk("w_stb", stb_cnt - s0, 1);
        chk("w_addr", wr_addr, 8'h12);
        chk("w_data", wr_data, 8'h80);
        dbg(8'h12, d);
        chk("w_reg12", d, 8'h80);

        // 2-phase write then 2-phase read with NA
        m_start;
        wr_byte(8'h42, ack);
        wr_byte(8'h12, ack);
        m_stop;
        m_start;
        wr_byte(8'h43, ack);
        chk("r_ack_dev", ack, 2'b10);
        rd_byte(1'b1, d, de9);
        chk("r_data", d, 8'h80);
        chk("r_de9", de9, 0);
        d0 = de_cnt;
        rd_byte(1'b1, d, de9);
        chk("r_ign_data", d, 8'hFF);
        chk("r_ign_de", de_cnt - d0, 0);
        m_stop;

        // Foreign device ID
        s0 = stb_cnt;
        d0 = de_cnt;
        m_start;
        wr_byte(8'h60, ack);
        chk("id_nak", ack, 2'b01);
        wr_byte(8'h12, ack);
        wr_byte(8'h55, ack);
        m_stop;
        chk("id_de", de_cnt - d0, 0);
        chk("id_stb", stb_cnt - s0, 0);
        dbg(8'h12, d);
        chk("id_reg12", d, 8'h80);

        // Repeated START after 4 data bits
        s0 = stb_cnt;
        m_start;
        wr_byte(8'h42, ack);
        wr_byte(8'h12, ack);
        clk_bit(1'b0, s, e);
        clk_bit(1'b1, s, e);
        clk_bit(1'b0, s, e);
        clk_bit(1'b1, s, e);
        m_start;
        wr_byte(8'h42, ack);
        wr_byte(8'h13, ack);
        wr_byte(8'hAA, ack);
        m_stop;
        chk("rs_stb", stb_cnt - s0, 1);
        chk("rs_addr", wr_addr, 8'h13);
        dbg(8'h12, d);
        chk("rs_reg12", d, 8'h80);
        dbg(8'h13, d);
        chk("rs_reg13", d, 8'hAA);

        // Burst at the top of the address space
        s0 = stb_cnt;
        m_start;
        wr_byte(8'h42, ack);
        wr_byte(8'hFF, ack);
        wr_byte(8'h01, ack);
        wr_byte(8'h02, ack);
        m_stop;
        chk("b_stb", stb_cnt - s0, 2);
`ifdef SCCB_SLV_AUTOINC_EN
        dbg(8'hFF, d);
        chk("b_regFF", d, 8'h01);
        dbg(8'h00, d);
        chk("b_reg00", d, 8'h02);
`else
        dbg(8'hFF, d);
        chk("b_regFF", d, 8'h02);
        dbg(8'h00, d);
        chk("b_reg00", d, 8'h00);
`endif

        // Reset in the middle of a read
        m_start;
        wr_byte(8'h42, ack);
        wr_byte(8'h12, ack);
        m_stop;
        m_start;
        wr_byte(8'h43, ack);
        clk_bit(1'b1, s, e);
        clk_bit(1'b1, s, e);
        clk_bit(1'b1, s, e);
        @(negedge clk);
        chk("mr_de_pre", sio.SIO_DE, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mr_de_rst", sio.SIO_DE, 0);
        wt(2);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mr_waddr", wr_addr, 0);
        m_sda = 1'b1;
        sio.SIO_C = 1'b1;
        wt(Q);
        dbg(8'h12, d);
        chk("mr_reg12", d, 8'h00);
        chk("mr_de_post", sio.SIO_DE, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
